// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the two-port ALU share arbiter: widths, requester IDs, request/response records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_share_pkg;

    localparam int CTRL_W = 5;
    localparam int TAG_W  = 5;
    localparam int CNT_W  = 32;

    // Port 0 is the main integer pipeline, port 1 the address/utility path.
    typedef enum logic {
        REQ_PIPE = 1'b0,
        REQ_AUX  = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       rs1_val;
        logic [31:0]       rs2_val;
        logic [CTRL_W-1:0] alu_control;
        logic [TAG_W-1:0]  tag;
    } alu_req_t;

    typedef struct packed {
        req_id_e          id;
        logic [TAG_W-1:0] tag;
        logic             wen;
        logic [31:0]      val;
    } alu_rsp_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from valids and the last winner.
// Latency: grant in the same cycle as valid; last winner updates on the advance edge.
// Backpressure: holds its priority state while advance is low.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Reset to 1 so that port 0 wins the first contention.
    logic r_last_grant;

    // One-hot grant: sole requester wins, otherwise the port that did not win last.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Remember the winner only when its op was actually accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (i_advance) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; registers the result in a one-entry response buffer.
// Latency: result visible one cycle after the request handshake; 1 op/cycle while rsp_ready is high.
// Backpressure: a held response with rsp_ready low blocks both request ports; reset blocks handshakes.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int CTRL_W = alu_share_pkg::CTRL_W,
    parameter int TAG_W  = alu_share_pkg::TAG_W,
    parameter int CNT_W  = alu_share_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [31:0]       req0_pc,
    input  logic [31:0]       req0_imm,
    input  logic [31:0]       req0_rs1_val,
    input  logic [31:0]       req0_rs2_val,
    input  logic [CTRL_W-1:0] req0_alu_control,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [31:0]       req1_pc,
    input  logic [31:0]       req1_imm,
    input  logic [31:0]       req1_rs1_val,
    input  logic [31:0]       req1_rs2_val,
    input  logic [CTRL_W-1:0] req1_alu_control,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [31:0]       alu_pc,
    output logic [31:0]       alu_imm,
    output logic [31:0]       alu_rs1_val,
    output logic [31:0]       alu_rs2_val,
    output logic [CTRL_W-1:0] alu_control,
    input  logic              alu_rd_write_control,
    input  logic [31:0]       alu_rd_write_val,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_wen,
    output logic [31:0]       rsp_val,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    alu_req_t         w_req0;
    alu_req_t         w_req1;
    alu_req_t         w_sel;
    logic [1:0]       w_grant;
    logic             w_can_accept;
    logic             w_hs0;
    logic             w_hs1;
    logic             w_hs;
    logic             r_rsp_valid;
    alu_rsp_t         r_rsp;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    assign w_req0 = '{pc: req0_pc, imm: req0_imm, rs1_val: req0_rs1_val,
                      rs2_val: req0_rs2_val, alu_control: req0_alu_control, tag: req0_tag};
    assign w_req1 = '{pc: req1_pc, imm: req1_imm, rs1_val: req1_rs1_val,
                      rs2_val: req1_rs2_val, alu_control: req1_alu_control, tag: req1_tag};

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_valid   ({req1_valid, req0_valid}),
        .i_advance (w_hs),
        .o_grant   (w_grant)
    );

    // A requester asserting ready during reset would think its op was taken, so reset blocks acceptance.
    assign w_can_accept = !rst && (!r_rsp_valid || rsp_ready);
    assign w_hs0        = w_grant[0] && w_can_accept;
    assign w_hs1        = w_grant[1] && w_can_accept;
    assign w_hs         = w_hs0 || w_hs1;
    assign req0_ready   = w_hs0;
    assign req1_ready   = w_hs1;

    // Operand mux: granted request drives the ALU even when the buffer is full; idle bus is all zero (no-op).
    always_comb begin
        w_sel = '0;
        if (w_grant[0]) begin
            w_sel = w_req0;
        end else if (w_grant[1]) begin
            w_sel = w_req1;
        end
    end

    assign alu_pc      = w_sel.pc;
    assign alu_imm     = w_sel.imm;
    assign alu_rs1_val = w_sel.rs1_val;
    assign alu_rs2_val = w_sel.rs2_val;
    assign alu_control = w_sel.alu_control;

    // Response buffer: capture on handshake (overwriting a draining entry), otherwise empty on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_hs) begin
            r_rsp_valid <= 1'b1;
            r_rsp.id    <= w_grant[1] ? REQ_AUX : REQ_PIPE;
            r_rsp.tag   <= w_sel.tag;
            r_rsp.wen   <= alu_rd_write_control;
            r_rsp.val   <= alu_rd_write_val;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Per-port accepted-op counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_hs0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_hs1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp.id;
    assign rsp_tag    = r_rsp.tag;
    assign rsp_wen    = r_rsp.wen;
    assign rsp_val    = r_rsp.val;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stands in for the shared ALU, keeps a transaction-level model, checks every cycle.
// Latency: n/a.
// Backpressure: exercised through rsp_ready in the directed sequence.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_pc = '0, req0_imm = '0, req0_rs1_val = '0, req0_rs2_val = '0;
    logic [31:0] req1_pc = '0, req1_imm = '0, req1_rs1_val = '0, req1_rs2_val = '0;
    logic [4:0]  req0_alu_control = '0, req1_alu_control = '0;
    logic [4:0]  req0_tag = '0, req1_tag = '0;
    logic [31:0] alu_pc, alu_imm, alu_rs1_val, alu_rs2_val;
    logic [4:0]  alu_control;
    logic        alu_rd_write_control;
    logic [31:0] alu_rd_write_val;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [4:0]  rsp_tag;
    logic        rsp_wen;
    logic [31:0] rsp_val;
    logic [31:0] grant_cnt0, grant_cnt1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc), .req0_imm(req0_imm),
        .req0_rs1_val(req0_rs1_val), .req0_rs2_val(req0_rs2_val),
        .req0_alu_control(req0_alu_control), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc), .req1_imm(req1_imm),
        .req1_rs1_val(req1_rs1_val), .req1_rs2_val(req1_rs2_val),
        .req1_alu_control(req1_alu_control), .req1_tag(req1_tag),
        .alu_pc(alu_pc), .alu_imm(alu_imm), .alu_rs1_val(alu_rs1_val), .alu_rs2_val(alu_rs2_val),
        .alu_control(alu_control),
        .alu_rd_write_control(alu_rd_write_control), .alu_rd_write_val(alu_rd_write_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_wen(rsp_wen), .rsp_val(rsp_val),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Stand-in ALU: 1 ADD, 2 SUB, 3 XOR, 4 PC+IMM; any other code writes nothing.
    function automatic logic [32:0] alu_fn(input logic [4:0] op, input logic [31:0] pc,
                                           input logic [31:0] imm, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'd1:    return {1'b1, a + b};
            5'd2:    return {1'b1, a - b};
            5'd3:    return {1'b1, a ^ b};
            5'd4:    return {1'b1, pc + imm};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    assign {alu_rd_write_control, alu_rd_write_val} =
        alu_fn(alu_control, alu_pc, alu_imm, alu_rs1_val, alu_rs2_val);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // The model tracks which requester won last, what the single held result is, and op counts.
    int          m_last;      // requester that most recently had an op accepted
    bit          m_full;
    int          m_id;
    logic [4:0]  m_tag;
    logic        m_wen;
    logic [31:0] m_val;
    longint      m_cnt[2];

    // Which requester is offered the ALU this cycle: -1 if none.
    function automatic int winner();
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit room();
        return !rst && (!m_full || rsp_ready);
    endfunction

    always @(posedge clk) begin
        int w;
        logic [32:0] r;
        w = winner();
        if (rst) begin
            m_full = 0; m_id = 0; m_tag = '0; m_wen = 0; m_val = '0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_last = 1;
        end else if (w >= 0 && room()) begin
            if (w == 0) begin
                r = alu_fn(req0_alu_control, req0_pc, req0_imm, req0_rs1_val, req0_rs2_val);
                m_tag = req0_tag;
            end else begin
                r = alu_fn(req1_alu_control, req1_pc, req1_imm, req1_rs1_val, req1_rs2_val);
                m_tag = req1_tag;
            end
            m_full = 1; m_id = w; m_wen = r[32]; m_val = r[31:0]; m_last = w;
            if (m_cnt[w] < 64'hFFFF_FFFF) m_cnt[w] = m_cnt[w] + 1;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int w;
            bit acc;
            w   = winner();
            acc = room();
            chk("m_req0_ready", 64'(req0_ready), 64'((w == 0) && acc));
            chk("m_req1_ready", 64'(req1_ready), 64'((w == 1) && acc));
            chk("m_alu_ctrl", 64'(alu_control),
                64'(w == 0 ? req0_alu_control : w == 1 ? req1_alu_control : 5'd0));
            chk("m_alu_rs1", 64'(alu_rs1_val),
                64'(w == 0 ? req0_rs1_val : w == 1 ? req1_rs1_val : 32'd0));
            chk("m_alu_rs2", 64'(alu_rs2_val),
                64'(w == 0 ? req0_rs2_val : w == 1 ? req1_rs2_val : 32'd0));
            chk("m_alu_pc", 64'(alu_pc), 64'(w == 0 ? req0_pc : w == 1 ? req1_pc : 32'd0));
            chk("m_alu_imm", 64'(alu_imm), 64'(w == 0 ? req0_imm : w == 1 ? req1_imm : 32'd0));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(m_full));
            if (m_full) begin
                chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
                chk("m_rsp_tag", 64'(rsp_tag), 64'(m_tag));
                chk("m_rsp_wen", 64'(rsp_wen), 64'(m_wen));
                chk("m_rsp_val", 64'(rsp_val), 64'(m_val));
            end
            chk("m_cnt0", 64'(grant_cnt0), 64'(m_cnt[0]));
            chk("m_cnt1", 64'(grant_cnt1), 64'(m_cnt[1]));
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        req0_valid = v; req0_alu_control = op; req0_rs1_val = a; req0_rs2_val = b; req0_tag = tag;
    endtask

    task automatic set1(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        req1_valid = v; req1_alu_control = op; req1_rs1_val = a; req1_rs2_val = b; req1_tag = tag;
    endtask

    initial begin
        int seq [4];
        seq = '{0, 1, 0, 1};

        rst = 1'b1;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_val", 64'(rsp_val), 64'd0);
        chk("rst_cnt0", 64'(grant_cnt0), 64'd0);
        chk("rst_cnt1", 64'(grant_cnt1), 64'd0);

        // Single ADD on port 0: 5 + 7.
        set0(1, 5'd1, 32'd5, 32'd7, 5'd3);
        #1;
        chk("single_ready0", 64'(req0_ready), 64'd1);
        chk("single_alu_rs1", 64'(alu_rs1_val), 64'd5);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("single_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("single_rsp_id", 64'(rsp_id), 64'd0);
        chk("single_rsp_tag", 64'(rsp_tag), 64'd3);
        chk("single_rsp_wen", 64'(rsp_wen), 64'd1);
        chk("single_rsp_val", 64'(rsp_val), 64'd12);
        chk("single_cnt0", 64'(grant_cnt0), 64'd1);

        // NOP on port 1 still returns a response, with no write.
        set1(1, 5'd0, 32'd99, 32'd1, 5'd9);
        #1;
        chk("nop_ready1", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        #1;
        chk("nop_rsp_wen", 64'(rsp_wen), 64'd0);
        chk("nop_rsp_tag", 64'(rsp_tag), 64'd9);
        chk("nop_rsp_id", 64'(rsp_id), 64'd1);

        // Contention for 4 cycles: port 1 won last, so grants go 0,1,0,1.
        set0(1, 5'd1, 32'd10, 32'd1, 5'd4);
        set1(1, 5'd1, 32'd20, 32'd2, 5'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", 64'(req0_ready), 64'(seq[i] == 0));
            chk("cont_ready1", 64'(req1_ready), 64'(seq[i] == 1));
            if (i > 0) chk("cont_rsp_id", 64'(rsp_id), 64'(seq[i-1]));
            cyc();
        end
        chk("cont_last_id", 64'(rsp_id), 64'd1);
        chk("cont_last_val", 64'(rsp_val), 64'd22);
        chk("cont_cnt0", 64'(grant_cnt0), 64'd3);
        chk("cont_cnt1", 64'(grant_cnt1), 64'd3);

        // Backpressure: response held, port 1 waits with SUB 50-8.
        req0_valid = 1'b0;
        set1(1, 5'd2, 32'd50, 32'd8, 5'd7);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready1", 64'(req1_ready), 64'd0);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_tag", 64'(rsp_tag), 64'd5);
            chk("bp_alu_rs1", 64'(alu_rs1_val), 64'd50);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready1", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        #1;
        chk("bp_rsp_tag_new", 64'(rsp_tag), 64'd7);
        chk("bp_rsp_val_new", 64'(rsp_val), 64'd42);
        chk("bp_rsp_id_new", 64'(rsp_id), 64'd1);
        chk("bp_cnt1", 64'(grant_cnt1), 64'd4);

        // Drain with no new requests: idle ALU bus, buffer empties.
        chk("drain_alu_ctrl", 64'(alu_control), 64'd0);
        chk("drain_alu_rs1", 64'(alu_rs1_val), 64'd0);
        cyc();
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);

        // Reset with a response held and both ports valid.
        set0(1, 5'd1, 32'd1, 32'd2, 5'd1);
        cyc();
        chk("mrst_pre_valid", 64'(rsp_valid), 64'd1);
        set1(1, 5'd3, 32'hF0, 32'h0F, 5'd2);
        rst = 1'b1;
        #1;
        chk("mrst_ready0", 64'(req0_ready), 64'd0);
        chk("mrst_ready1", 64'(req1_ready), 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mrst_cnt0", 64'(grant_cnt0), 64'd0);
        chk("mrst_cnt1", 64'(grant_cnt1), 64'd0);
        chk("mrst_first_ready0", 64'(req0_ready), 64'd1);
        chk("mrst_first_ready1", 64'(req1_ready), 64'd0);
        cyc();
        req0_valid = 1'b0;
        #1;
        chk("mrst_rsp_id", 64'(rsp_id), 64'd0);
        chk("mrst_rsp_val", 64'(rsp_val), 64'd3);
        // Port 1 has been waiting and now runs XOR.
        #1;
        chk("mrst_ready1_next", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        #1;
        chk("mrst_xor_val", 64'(rsp_val), 64'hFF);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational execute ALU between two requesters: port 0 is the main integer pipeline, port 1 is the secondary address/utility path.
- Round-robin arbitration with valid/ready handshakes on the inputs.
- Drives the ALU operand bus from the granted request and registers the ALU result into a one-entry response buffer, with valid/ready and requester ID.
- Sits between the decode/issue logic and the shared alu instance at processor top level; the ALU itself is instantiated outside this block.

Parameters:
- CTRL_W, 5, ALU control code width; matches the ALU alu_control input.
- TAG_W, 5, opaque destination tag width; carries rd index.
- CNT_W, 32, width of the per-port grant counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- reqN_valid  input  1  request N valid (N=0,1)
- reqN_ready  output  1  request N accepted this cycle
- reqN_pc  input  32  PC operand
- reqN_imm  input  32  immediate operand
- reqN_rs1_val  input  32  rs1 operand
- reqN_rs2_val  input  32  rs2 operand
- reqN_alu_control  input  CTRL_W  ALU op code
- reqN_tag  input  TAG_W  opaque tag, returned unchanged
- alu_pc, alu_imm, alu_rs1_val, alu_rs2_val  output  32 each  operands to the shared ALU
- alu_control  output  CTRL_W  op to the shared ALU
- alu_rd_write_control  input  1  ALU write-enable result
- alu_rd_write_val  input  32  ALU result value
- rsp_valid  output  1  response buffer holds a result
- rsp_ready  input  1  consumer takes the response
- rsp_id  output  1  requester that issued the op (0/1)
- rsp_tag  output  TAG_W  tag of the op
- rsp_wen  output  1  registered alu_rd_write_control
- rsp_val  output  32  registered alu_rd_write_val
- grant_cnt0, grant_cnt1  output  CNT_W  accepted-op counters

Behaviour:
- Reset (rst=1 at a clk edge), all registers cleared:
  - rsp_valid, rsp_id, rsp_tag, rsp_wen, rsp_val all 0.
  - grant_cnt0 and grant_cnt1 = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Reset mid-operation drops any buffered response; no handshake completes in that cycle.
- can_accept = !rsp_valid || rsp_ready.
- Grant (combinational, from valids and last_grant only; never from ready):
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - Neither valid: no grant.
- reqN_ready = grantN && can_accept. At most one ready per cycle.
- Requester rules: valid must not depend on ready; payload stays stable while valid && !ready.
- ALU bus:
  - Granted request's operands/control are muxed onto alu_* combinationally, whether or not can_accept holds.
  - No grant: all alu_* = 0. alu_control=0 is a no-op; the ALU returns wen 0.
- Handshake on port N at edge E:
  - rsp_val ← alu_rd_write_val, rsp_wen ← alu_rd_write_control.
  - rsp_id ← N, rsp_tag ← reqN_tag, rsp_valid ← 1.
  - last_grant ← N.
  - grant_cntN increments, saturating at all-ones.
- Latency: result visible one cycle after the handshake cycle.
- Throughput: 1 op/cycle while rsp_ready is held high.
- Response drain: rsp_valid && rsp_ready with no new handshake → rsp_valid ← 0. Drain and a new handshake in the same cycle → buffer overwritten with the new op, rsp_valid stays 1.
- Backpressure: rsp_valid && !rsp_ready → both readies 0; buffer and last_grant hold.
- Ops with result wen=0 (NOP, unmapped codes) still produce a response with rsp_wen=0.
- Arithmetic and width rules are owned by the ALU. This block adds no sign or width handling; 32-bit values pass through unmodified.

Decomposition:
- Package alu_share_pkg:
  - CTRL_W and TAG_W constants.
  - Requester ID enum: REQ_PIPE=0, REQ_AUX=1.
  - Packed struct alu_req_t {pc, imm, rs1_val, rs2_val, alu_control, tag}.
  - Packed struct alu_rsp_t {id, tag, wen, val}.
- One sub-module, rr_arb2: two-way round-robin arbiter holding last_grant. Inputs: valid[1:0], advance. Output: one-hot grant[1:0].
- The top contains the operand mux, response buffer and counters.

Test Plan:
- Reset then single request: req0 ADD with rs1=5, rs2=7, tag=3, rsp_ready=1 → req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_tag=3, rsp_wen=1, rsp_val=12; grant_cnt0=1.
- Contention: both ports valid continuously for 4 cycles, rsp_ready=1 → grants 0,1,0,1; rsp_id sequence 0,1,0,1; both counters=2.
- Backpressure: rsp_ready=0 with a response pending and req1 valid → req1_ready=0 and rsp_* stable for 3 cycles; rsp_ready=1 → req1 accepted that cycle, result appears the next cycle.
- Drain without refill: a response pending, rsp_ready=1, no valids → rsp_valid drops to 0 next cycle; alu_control=0.
- NOP op: req1 with alu_control=0, tag=9 → response rsp_wen=0, rsp_tag=9, rsp_id=1.
- Mid-operation reset: rst asserted while rsp_valid=1 and both ports valid → next cycle rsp_valid=0, counters=0; first grant after reset goes to port 0.
